branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with saturating-counter direction prediction. It replaces the fixed `npc = pc + 1` guess in the fetch stage. Fetch looks up the current word-address PC combinationally and gets a predicted next PC. Execute writes back the resolved outcome of each instruction one time, qualified by the cache stall, so the predictor learns branch and jump targets and keeps mispredict statistics.

## Interface
- `PC_W`, 30: PC width in word addresses (byte address / 4).
- `ENTRIES`, 16: number of BTB entries. Must be a power of two, at least 2. `IDX_W = log2(ENTRIES)`.
- `TAG_W`, 8: stored tag width. Requires `IDX_W + TAG_W <= PC_W`.
- `CTR_W`, 2: direction counter width, at least 1.
- `CNT_W`, 32: statistics counter width.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: pipeline frozen (memory hazard). When high, it blocks all updates and counts.
- `clear` in 1: synchronous invalidate-all.
- `fe_pc` in PC_W: fetch PC to predict.
- `pred_npc` out PC_W: predicted next fetch PC (combinational).
- `pred_taken` out 1: prediction is taken (combinational).
- `pred_hit` out 1: BTB tag hit for `fe_pc` (combinational).
- `upd_valid` in 1: an EX-stage instruction is resolving this cycle.
- `upd_pc` in PC_W: PC of the resolving instruction.
- `upd_branch` in 1: the instruction is a branch or jump.
- `upd_taken` in 1: resolved direction.
- `upd_target` in PC_W: resolved taken target (word address).
- `upd_mispredict` in 1: the fetch prediction for this instruction was wrong.
- `branch_cnt` out CNT_W: count of resolved branches and jumps.
- `mispred_cnt` out CNT_W: count of mispredictions.

## Operation
- Each entry holds `valid`, `tag[TAG_W]`, `target[PC_W]` and `ctr[CTR_W]`.
- Index is `pc[IDX_W-1:0]`. Tag is `pc[IDX_W+TAG_W-1:IDX_W]`.
- Lookup:
  - `pred_hit = valid[idx] && tag[idx]==fe_tag`.
  - `pred_taken = pred_hit && ctr[idx][CTR_W-1]`.
  - `pred_npc = pred_taken ? target[idx] : fe_pc+1`, with the increment wrapping modulo 2^PC_W.
- Update enable is `upd_en = upd_valid && !stall`. Lookup is done on the same index and tag fields of `upd_pc`.
- Update actions when `upd_en` is high:
  - Branch, hit, taken: `ctr` increments, saturating at 2^CTR_W-1. `target <= upd_target`.
  - Branch, hit, not taken: `ctr` decrements, saturating at 0. Target is unchanged.
  - Branch, miss, taken: allocate the entry, overwriting any alias. Set `valid=1`, write the tag and target, and set `ctr = 1<<(CTR_W-1)` (weakly taken).
  - Branch, miss, not taken: no change.
  - Non-branch that hits: clear `valid` (removes aliasing garbage). A non-branch that misses causes no change.
- Statistics:
  - `branch_cnt` increments on `upd_en && upd_branch`.
  - `mispred_cnt` increments on `upd_en && upd_mispredict`.
  - Both saturate at all-ones and never wrap.
- Priority order is `rst`, then `clear`, then update:
  - `clear` zeroes all `valid` and `ctr`, and ignores any same-cycle update.
  - `clear` does not affect the statistics counters, and the statistics still count that cycle's update.
- `rst` zeroes all `valid`, all `ctr`, and both statistics counters. `tag` and `target` are not reset.

## Timing
- Lookup has zero latency: outputs are combinational from `fe_pc` and the registered table.
- An update becomes visible to lookup on the cycle after the edge at which `upd_en` is sampled.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- Stall protocol:
  - The EX stage holds the `upd_*` signals stable while `stall` is high.
  - The update is applied exactly once, on the first edge where `stall` is low.
  - Lookup outputs stay valid during stall.
- Reset values after `rst`:
  - `pred_hit=0` and `pred_taken=0` for every PC, and `pred_npc=fe_pc+1`.
  - `branch_cnt=0` and `mispred_cnt=0`.
- Reset applied mid-operation discards the same-cycle update.

## Test plan
- Reset, then sweep `fe_pc` over 0..2*ENTRIES → `pred_hit=0`, `pred_npc=fe_pc+1`. At `fe_pc=2^PC_W-1`, `pred_npc=0`. Both counts are 0.
- Update pc=0x10, branch, taken, target=0x40, then look up 0x10 → hit, taken, npc=0x40, `branch_cnt=1`. Then apply three not-taken updates → `ctr` goes 2→1→0→0 and the prediction is not taken from the first decrement on (npc=0x11).
- Alias test (ENTRIES=16): allocate 0x10→0x40, look up 0x110 → miss. A taken update at 0x110→0x80 evicts the first entry, and a lookup of 0x10 then misses.
- Assert `stall` for 3 cycles with a taken update plus `upd_mispredict` held → no table or count change during the stall. After release, exactly one allocation happens and `mispred_cnt=1`.
- Same cycle: lookup 0x10 plus an allocating update of 0x10 → the old miss is returned that cycle and a hit on the next cycle. A non-branch update to a hit entry → the next lookup misses.
- `clear` coincident with a taken branch update → all entries invalid and no allocation, while `branch_cnt` still increments. Force `branch_cnt` to all-ones (CNT_W=4) → it holds at 15.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating direction counters and mispredict statistics.
// Lookup is combinational from fe_pc; resolved outcomes train the table one edge later.
module branch_predictor #(
    parameter int PC_W    = 30,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             clear,
    input  logic [PC_W-1:0]  fe_pc,
    output logic [PC_W-1:0]  pred_npc,
    output logic             pred_taken,
    output logic             pred_hit,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_branch,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [IDX_W-1:0] fe_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] fe_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_en;
    logic             upd_hit;
    logic             unused_pc_bits;

    logic             valid_rd  [ENTRIES];
    logic [TAG_W-1:0] tag_rd    [ENTRIES];
    logic [PC_W-1:0]  target_rd [ENTRIES];
    logic [CTR_W-1:0] ctr_rd    [ENTRIES];

    logic [CNT_W-1:0] branch_cnt_reg;
    logic [CNT_W-1:0] mispred_cnt_reg;

    assign fe_idx  = fe_pc[IDX_W-1:0];
    assign fe_tag  = fe_pc[IDX_W+TAG_W-1:IDX_W];
    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[IDX_W+TAG_W-1:IDX_W];
    assign upd_en  = upd_valid && !stall;
    assign upd_hit = valid_rd[upd_idx] && (tag_rd[upd_idx] == upd_tag);

    // Upper PC bits above the tag take no part in indexing or matching.
    assign unused_pc_bits = ^upd_pc;

    assign pred_hit   = valid_rd[fe_idx] && (tag_rd[fe_idx] == fe_tag);
    assign pred_taken = pred_hit && ctr_rd[fe_idx][CTR_W-1];
    assign pred_npc   = pred_taken ? target_rd[fe_idx] : fe_pc + PC_W'(1);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [PC_W-1:0]  target_reg;
            logic [CTR_W-1:0] ctr_reg;
            logic             sel;

            assign sel = upd_en && (upd_idx == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= '0;
                end else if (sel) begin
                    if (upd_branch) begin
                        if (upd_hit) begin
                            if (upd_taken) begin
                                if (ctr_reg != CTR_MAX) ctr_reg <= ctr_reg + 1'b1;
                            end else if (ctr_reg != '0) begin
                                ctr_reg <= ctr_reg - 1'b1;
                            end
                        end else if (upd_taken) begin
                            valid_reg <= 1'b1;
                            ctr_reg   <= CTR_WEAK;
                        end
                    end else if (upd_hit) begin
                        valid_reg <= 1'b0;
                    end
                end
            end

            // Tag and target carry no reset; they only matter once valid is set.
            always_ff @(posedge clk) begin
                if (!rst && !clear && sel && upd_branch && upd_taken) begin
                    tag_reg    <= upd_tag;
                    target_reg <= upd_target;
                end
            end

            assign valid_rd[gi]  = valid_reg;
            assign tag_rd[gi]    = tag_reg;
            assign target_rd[gi] = target_reg;
            assign ctr_rd[gi]    = ctr_reg;
        end
    endgenerate

    // Statistics ignore clear and saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else if (upd_en) begin
            if (upd_branch && branch_cnt_reg != CNT_MAX)
                branch_cnt_reg <= branch_cnt_reg + 1'b1;
            if (upd_mispredict && mispred_cnt_reg != CNT_MAX)
                mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
        end
    end

    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected lookup results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;
    localparam int PC_W  = 30;
    localparam int CNT_W = 4;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic             hit;
        logic             taken;
        logic [PC_W-1:0]  npc;
        logic [CNT_W-1:0] b;
        logic [CNT_W-1:0] m;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             clear;
    logic [PC_W-1:0]  fe_pc;
    logic [PC_W-1:0]  pred_npc;
    logic             pred_taken;
    logic             pred_hit;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_branch;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_target;
    logic             upd_mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    exp_t exp_q[$];
    logic sample = 1'b0;
    int   total = 0;
    int   bad = 0;

    branch_predictor #(
        .PC_W(PC_W), .ENTRIES(16), .TAG_W(8), .CTR_W(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .clear(clear),
        .fe_pc(fe_pc), .pred_npc(pred_npc), .pred_taken(pred_taken), .pred_hit(pred_hit),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_branch(upd_branch),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach the end, got=running want=finished");
        $fatal(1, "timeout");
    end

    // Monitor: one transaction per sampled cycle.
    always @(negedge clk) begin
        if (sample) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL lookup: no expected entry queued, got=sample want=queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pred_hit !== e.hit || pred_taken !== e.taken || pred_npc !== e.npc ||
                    branch_cnt !== e.b || mispred_cnt !== e.m) begin
                    bad++;
                    $display("FAIL lookup pc=%h: got hit=%b taken=%b npc=%h bcnt=%0d mcnt=%0d want hit=%b taken=%b npc=%h bcnt=%0d mcnt=%0d",
                             e.pc, pred_hit, pred_taken, pred_npc, branch_cnt, mispred_cnt,
                             e.hit, e.taken, e.npc, e.b, e.m);
                end else begin
                    $display("ok   lookup pc=%h hit=%b taken=%b npc=%h bcnt=%0d mcnt=%0d",
                             e.pc, pred_hit, pred_taken, pred_npc, branch_cnt, mispred_cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic lk(input logic [PC_W-1:0] pc, input logic h, input logic t,
                      input logic [PC_W-1:0] npc, input logic [CNT_W-1:0] b,
                      input logic [CNT_W-1:0] m);
        exp_t e;
        e.pc = pc; e.hit = h; e.taken = t; e.npc = npc; e.b = b; e.m = m;
        fe_pc = pc;
        exp_q.push_back(e);
        sample = 1'b1;
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic br, input logic tk,
                       input logic [PC_W-1:0] tgt, input logic mp);
        upd_valid = 1'b1; upd_pc = pc; upd_branch = br;
        upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
    endtask

    task automatic no_upd();
        upd_valid = 1'b0; upd_branch = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    endtask

    initial begin
        logic [CNT_W-1:0] bm;
        rst = 1'b1; stall = 1'b0; clear = 1'b0; fe_pc = '0;
        upd_pc = '0; upd_target = '0;
        no_upd();
        tick(); tick();
        rst = 1'b0;

        // Reset state sweep and wrap of the sequential guess.
        for (int i = 0; i <= 32; i++) begin
            lk(PC_W'(i), 1'b0, 1'b0, PC_W'(i + 1), 4'd0, 4'd0); tick();
        end
        lk(30'h3FFF_FFFF, 1'b0, 1'b0, 30'h0, 4'd0, 4'd0); tick();

        // Allocate, then train down with three not-taken outcomes.
        upd(30'h10, 1'b1, 1'b1, 30'h40, 1'b0); tick();
        no_upd();
        lk(30'h10, 1'b1, 1'b1, 30'h40, 4'd1, 4'd0); tick();
        upd(30'h10, 1'b1, 1'b0, 30'h0, 1'b0);
        lk(30'h10, 1'b1, 1'b1, 30'h40, 4'd1, 4'd0); tick();
        lk(30'h10, 1'b1, 1'b0, 30'h11, 4'd2, 4'd0); tick();
        lk(30'h10, 1'b1, 1'b0, 30'h11, 4'd3, 4'd0); tick();
        no_upd();
        lk(30'h10, 1'b1, 1'b0, 30'h11, 4'd4, 4'd0); tick();

        // Non-branch hit invalidates; then alias eviction.
        upd(30'h10, 1'b0, 1'b0, 30'h0, 1'b0); tick();
        no_upd();
        lk(30'h10, 1'b0, 1'b0, 30'h11, 4'd4, 4'd0); tick();
        upd(30'h10, 1'b1, 1'b1, 30'h40, 1'b0); tick();
        no_upd();
        lk(30'h10, 1'b1, 1'b1, 30'h40, 4'd5, 4'd0); tick();
        lk(30'h110, 1'b0, 1'b0, 30'h111, 4'd5, 4'd0); tick();
        upd(30'h110, 1'b1, 1'b1, 30'h80, 1'b0); tick();
        no_upd();
        lk(30'h10, 1'b0, 1'b0, 30'h11, 4'd6, 4'd0); tick();
        lk(30'h110, 1'b1, 1'b1, 30'h80, 4'd6, 4'd0); tick();

        // Stall holds the update for three cycles; applied once after release.
        stall = 1'b1;
        upd(30'h20, 1'b1, 1'b1, 30'h55, 1'b1);
        for (int i = 0; i < 3; i++) begin
            lk(30'h20, 1'b0, 1'b0, 30'h21, 4'd6, 4'd0); tick();
        end
        stall = 1'b0;
        lk(30'h20, 1'b0, 1'b0, 30'h21, 4'd6, 4'd0); tick();
        no_upd();
        lk(30'h20, 1'b1, 1'b1, 30'h55, 4'd7, 4'd1); tick();
        lk(30'h20, 1'b1, 1'b1, 30'h55, 4'd7, 4'd1); tick();

        // Same-cycle lookup returns pre-update contents.
        upd(30'h30, 1'b1, 1'b1, 30'h99, 1'b0);
        lk(30'h30, 1'b0, 1'b0, 30'h31, 4'd7, 4'd1); tick();
        no_upd();
        lk(30'h30, 1'b1, 1'b1, 30'h99, 4'd8, 4'd1); tick();

        // Clear wins over the table update but the counter still counts.
        clear = 1'b1;
        upd(30'h40, 1'b1, 1'b1, 30'h12, 1'b0);
        lk(30'h30, 1'b1, 1'b1, 30'h99, 4'd8, 4'd1); tick();
        clear = 1'b0;
        no_upd();
        lk(30'h40, 1'b0, 1'b0, 30'h41, 4'd9, 4'd1); tick();
        lk(30'h30, 1'b0, 1'b0, 30'h31, 4'd9, 4'd1); tick();
        lk(30'h110, 1'b0, 1'b0, 30'h111, 4'd9, 4'd1); tick();
        lk(30'h20, 1'b0, 1'b0, 30'h21, 4'd9, 4'd1); tick();

        // Saturation of branch_cnt at all-ones.
        bm = 4'd9;
        upd(30'h5, 1'b1, 1'b0, 30'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            lk(30'h5, 1'b0, 1'b0, 30'h6, bm, 4'd1); tick();
            if (bm != 4'hF) bm = bm + 4'd1;
        end
        no_upd();
        lk(30'h5, 1'b0, 1'b0, 30'h6, 4'hF, 4'd1); tick();

        // Reset mid-operation discards the coincident update.
        upd(30'h50, 1'b1, 1'b1, 30'h7, 1'b1);
        rst = 1'b1; tick();
        rst = 1'b0;
        no_upd();
        lk(30'h50, 1'b0, 1'b0, 30'h51, 4'd0, 4'd0); tick();
        tick(); tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0 pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
